// File: rtl/cphase_rotation_sequencer.sv
// Sequencer that applies a QFT controlled-phase R_k rotation in place over the amplitude memory:
// every amplitude whose control and target bits are both set is read, multiplied by the twiddle and written back.
module cphase_rotation_sequencer #(
  parameter int INT_WIDTH   = 8,
  parameter int FRAC_WIDTH  = 8,
  parameter int NUM_QUBITS  = 3,
  parameter int QIDX_WIDTH  = 2,
  parameter int MUL_TIMEOUT = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [QIDX_WIDTH-1:0]                 cmd_ctrl,
  input  logic [QIDX_WIDTH-1:0]                 cmd_tgt,
  input  logic [2:0]                            cmd_k,
  output logic [NUM_QUBITS-1:0]                 mem_addr,
  output logic                                  mem_rd_en,
  input  logic signed [INT_WIDTH+FRAC_WIDTH-1:0] mem_rd_real,
  input  logic signed [INT_WIDTH+FRAC_WIDTH-1:0] mem_rd_imag,
  output logic                                  mem_wr_en,
  output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] mem_wr_real,
  output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] mem_wr_imag,
  output logic                                  mul_start,
  output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] mul_a_real,
  output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] mul_a_imag,
  output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] mul_b_real,
  output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] mul_b_imag,
  input  logic signed [INT_WIDTH+FRAC_WIDTH-1:0] mul_out_real,
  input  logic signed [INT_WIDTH+FRAC_WIDTH-1:0] mul_out_imag,
  input  logic                                  mul_done,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int DW = INT_WIDTH + FRAC_WIDTH;
  localparam int TW = $clog2(MUL_TIMEOUT) + 1;
  localparam int SH = 16 - FRAC_WIDTH;

  typedef enum logic [2:0] {
    IDLE, SCAN, LOAD, START, WAIT, WRITE, FINISH, ABORT
  } state_t;

  state_t                  state, state_d;
  logic [NUM_QUBITS-1:0]   idx;
  logic [QIDX_WIDTH-1:0]   ctrl_q, tgt_q;
  logic [TW-1:0]           wait_cnt;
  logic                    match, last, cmd_illegal;
  logic signed [DW-1:0]    tw_real, tw_imag;

  // Twiddles are kept as Q.16 constants and rounded to the amplitude's fractional width (FRAC_WIDTH <= 16).
  function automatic logic signed [DW-1:0] q16_to_fmt(input int v);
    int r;
    r = (v + ((1 <<< SH) >>> 1)) >>> SH;
    return DW'(r);
  endfunction

  always_comb begin
    tw_real = '0;
    tw_imag = '0;
    case (cmd_k)
      3'd1: begin tw_real = q16_to_fmt(-65536); tw_imag = q16_to_fmt(0);     end
      3'd2: begin tw_real = q16_to_fmt(0);      tw_imag = q16_to_fmt(65536); end
      3'd3: begin tw_real = q16_to_fmt(46341);  tw_imag = q16_to_fmt(46341); end
      3'd4: begin tw_real = q16_to_fmt(60547);  tw_imag = q16_to_fmt(25080); end
      default: ;
    endcase
  end

  assign cmd_illegal = (cmd_k == 3'd0) || (cmd_k > 3'd4) || (cmd_ctrl == cmd_tgt)
                     || (int'(cmd_ctrl) >= NUM_QUBITS) || (int'(cmd_tgt) >= NUM_QUBITS);
  assign match = idx[ctrl_q] & idx[tgt_q];
  assign last  = &idx;

  always_comb begin
    state_d   = state;
    cmd_ready = 1'b0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mul_start = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_illegal ? ABORT : SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (match) begin
          mem_addr  = idx;
          mem_rd_en = 1'b1;
          state_d   = LOAD;
        end else if (last) begin
          state_d = FINISH;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        state_d = START;
      end
      START: begin
        busy      = 1'b1;
        mul_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (mul_done) state_d = WRITE;
        else if (wait_cnt == TW'(MUL_TIMEOUT - 1)) state_d = ABORT;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_addr  = idx;
        mem_wr_en = 1'b1;
        state_d   = last ? FINISH : SCAN;
      end
      FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      ABORT: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands stay registered from LOAD until the next amplitude so the multiplier sees stable inputs in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      ctrl_q      <= '0;
      tgt_q       <= '0;
      wait_cnt    <= '0;
      mul_a_real  <= '0;
      mul_a_imag  <= '0;
      mul_b_real  <= '0;
      mul_b_imag  <= '0;
      mem_wr_real <= '0;
      mem_wr_imag <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ctrl_q     <= cmd_ctrl;
            tgt_q      <= cmd_tgt;
            idx        <= '0;
            mul_b_real <= tw_real;
            mul_b_imag <= tw_imag;
          end
        end
        SCAN: begin
          if (!match && !last) idx <= idx + 1'b1;
        end
        LOAD: begin
          mul_a_real <= mem_rd_real;
          mul_a_imag <= mem_rd_imag;
        end
        START: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (mul_done) begin
            mem_wr_real <= mul_out_real;
            mem_wr_imag <= mul_out_imag;
          end
        end
        WRITE: begin
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cphase_rotation_sequencer.sv
// Directed bench for cphase_rotation_sequencer with a behavioural amplitude memory and a 3-cycle multiplier stub.
module tb_cphase_rotation_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_ctrl = '0, cmd_tgt = '0;
  logic [2:0] cmd_k = '0;
  logic [2:0] mem_addr;
  logic mem_rd_en, mem_wr_en, mul_start, mul_done, busy, done, err;
  logic signed [15:0] mem_rd_real, mem_rd_imag, mem_wr_real, mem_wr_imag;
  logic signed [15:0] mul_a_real, mul_a_imag, mul_b_real, mul_b_imag;
  logic signed [15:0] mul_out_real, mul_out_imag;

  int checks = 0;
  int fails = 0;

  cphase_rotation_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ctrl(cmd_ctrl), .cmd_tgt(cmd_tgt), .cmd_k(cmd_k),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_real(mem_rd_real), .mem_rd_imag(mem_rd_imag),
    .mem_wr_en(mem_wr_en), .mem_wr_real(mem_wr_real), .mem_wr_imag(mem_wr_imag),
    .mul_start(mul_start),
    .mul_a_real(mul_a_real), .mul_a_imag(mul_a_imag),
    .mul_b_real(mul_b_real), .mul_b_imag(mul_b_imag),
    .mul_out_real(mul_out_real), .mul_out_imag(mul_out_imag),
    .mul_done(mul_done),
    .busy(busy), .done(done), .err(err)
  );

  // Amplitude memory: one-cycle read latency, plus a preload port used only while the DUT is idle.
  logic signed [15:0] mem_r [8];
  logic signed [15:0] mem_i [8];
  logic pl_en = 1'b0;
  logic [2:0] pl_addr = '0;
  logic signed [15:0] pl_r = '0, pl_i = '0;
  int wr_count = 0;
  int rd_count = 0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem_r[pl_addr] <= pl_r;
      mem_i[pl_addr] <= pl_i;
    end else if (mem_wr_en) begin
      mem_r[mem_addr] <= mem_wr_real;
      mem_i[mem_addr] <= mem_wr_imag;
      wr_count <= wr_count + 1;
    end
    if (mem_rd_en) begin
      mem_rd_real <= mem_r[mem_addr];
      mem_rd_imag <= mem_i[mem_addr];
      rd_count <= rd_count + 1;
    end
  end

  // Multiplier stub: Q8.8 complex product with truncation, done on the 3rd cycle after start.
  logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic mul_en = 1'b1;
  logic signed [15:0] prod_r = '0, prod_i = '0;

  always @(posedge clk) begin
    d1 <= mul_start;
    d2 <= d1;
    d3 <= d2;
    if (mul_start) begin
      prod_r <= 16'((longint'(mul_a_real) * longint'(mul_b_real)
                   - longint'(mul_a_imag) * longint'(mul_b_imag)) >>> 8);
      prod_i <= 16'((longint'(mul_a_real) * longint'(mul_b_imag)
                   + longint'(mul_a_imag) * longint'(mul_b_real)) >>> 8);
    end
  end

  assign mul_done     = d3 & mul_en;
  assign mul_out_real = prod_r;
  assign mul_out_imag = prod_i;

  task automatic preload(input int a, input int r, input int i);
    pl_en = 1'b1;
    pl_addr = 3'(a);
    pl_r = 16'(r);
    pl_i = 16'(i);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first cycle after acceptance.
  task automatic send_cmd(input int c, input int t, input int k);
    cmd_ctrl = 2'(c);
    cmd_tgt = 2'(t);
    cmd_k = 3'(k);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts cycles after acceptance (first cycle = 1) until done or err is seen, bounded by limit.
  task automatic wait_event(input bit on_err, input int limit, output int n);
    n = 1;
    while (!(on_err ? err : done) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_cmd_ready: got %b, want 1", cmd_ready);
    end
    checks++;
    if ({busy, done, err, mem_rd_en, mem_wr_en, mul_start} !== 6'b0) begin
      fails++; $display("[TB] FAIL reset_strobes: got %b, want 000000",
                        {busy, done, err, mem_rd_en, mem_wr_en, mul_start});
    end
    checks++;
    if (mem_addr !== 3'd0 || mul_a_real !== 16'sd0 || mul_b_real !== 16'sd0 || mem_wr_real !== 16'sd0) begin
      fails++; $display("[TB] FAIL reset_data: addr %0d a %0d b %0d wr %0d, want all 0",
                        mem_addr, mul_a_real, mul_b_real, mem_wr_real);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rotate_k1();
    int n, wb, rb;
    bit busy_ok;
    for (int a = 0; a < 8; a++) preload(a, a * 16 + 1, -a - 2);
    preload(3, 256, 0);
    preload(7, 0, 128);
    wb = wr_count;
    rb = rd_count;
    send_cmd(0, 1, 1);
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 21) begin fails++; $display("[TB] FAIL k1_done_latency: got %0d, want 21", n); end
    checks++;
    if (!busy_ok) begin fails++; $display("[TB] FAIL k1_busy: got busy low mid-command, want high"); end
    checks++;
    if (wr_count - wb != 2 || rd_count - rb != 2) begin
      fails++; $display("[TB] FAIL k1_access_count: wr %0d rd %0d, want 2 2", wr_count - wb, rd_count - rb);
    end
    checks++;
    if (mem_r[3] !== -16'sd256 || mem_i[3] !== 16'sd0) begin
      fails++; $display("[TB] FAIL k1_amp3: got (%0d,%0d), want (-256,0)", mem_r[3], mem_i[3]);
    end
    checks++;
    if (mem_r[7] !== 16'sd0 || mem_i[7] !== -16'sd128) begin
      fails++; $display("[TB] FAIL k1_amp7: got (%0d,%0d), want (0,-128)", mem_r[7], mem_i[7]);
    end
    for (int a = 0; a < 8; a++) begin
      if (a != 3 && a != 7) begin
        checks++;
        if (mem_r[a] !== 16'(a * 16 + 1) || mem_i[a] !== 16'(-a - 2)) begin
          fails++; $display("[TB] FAIL k1_untouched[%0d]: got (%0d,%0d), want (%0d,%0d)",
                            a, mem_r[a], mem_i[a], a * 16 + 1, -a - 2);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL k1_after_done: done %b busy %b ready %b, want 0 0 1", done, busy, cmd_ready);
    end
  endtask

  task automatic test_rotate_k2_k3();
    int n;
    for (int a = 0; a < 8; a++) preload(a, a * 16 + 1, -a - 2);
    preload(5, 256, 0);
    preload(7, 100, 50);
    send_cmd(2, 0, 2);
    wait_event(1'b0, 100, n);
    checks++;
    if (n != 21) begin fails++; $display("[TB] FAIL k2_done_latency: got %0d, want 21", n); end
    checks++;
    if (mem_r[5] !== 16'sd0 || mem_i[5] !== 16'sd256) begin
      fails++; $display("[TB] FAIL k2_amp5: got (%0d,%0d), want (0,256)", mem_r[5], mem_i[5]);
    end
    checks++;
    if (mem_r[7] !== -16'sd50 || mem_i[7] !== 16'sd100) begin
      fails++; $display("[TB] FAIL k2_amp7: got (%0d,%0d), want (-50,100)", mem_r[7], mem_i[7]);
    end
    for (int a = 0; a < 8; a++) begin
      if (a != 5 && a != 7) begin
        checks++;
        if (mem_r[a] !== 16'(a * 16 + 1) || mem_i[a] !== 16'(-a - 2)) begin
          fails++; $display("[TB] FAIL k2_untouched[%0d]: got (%0d,%0d), want (%0d,%0d)",
                            a, mem_r[a], mem_i[a], a * 16 + 1, -a - 2);
        end
      end
    end
    @(negedge clk);
    preload(5, 256, 0);
    send_cmd(2, 0, 3);
    wait_event(1'b0, 100, n);
    checks++;
    if (mem_r[5] !== 16'sd181 || mem_i[5] !== 16'sd181) begin
      fails++; $display("[TB] FAIL k3_amp5: got (%0d,%0d), want (181,181)", mem_r[5], mem_i[5]);
    end
    checks++;
    if (mem_r[7] !== -16'sd107 || mem_i[7] !== 16'sd35) begin
      fails++; $display("[TB] FAIL k3_amp7: got (%0d,%0d), want (-107,35)", mem_r[7], mem_i[7]);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int vc[4] = '{1, 0, 0, 3};
    int vt[4] = '{1, 1, 1, 0};
    int vk[4] = '{2, 0, 5, 1};
    int wb, rb;
    for (int v = 0; v < 4; v++) begin
      wb = wr_count;
      rb = rd_count;
      send_cmd(vc[v], vt[v], vk[v]);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        fails++; $display("[TB] FAIL illegal%0d_err: err %b busy %b, want 1 0", v, err, busy);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        fails++; $display("[TB] FAIL illegal%0d_after: err %b busy %b ready %b, want 0 0 1",
                          v, err, busy, cmd_ready);
      end
      checks++;
      if (wr_count != wb || rd_count != rb) begin
        fails++; $display("[TB] FAIL illegal%0d_mem: wr %0d rd %0d, want 0 0", v, wr_count - wb, rd_count - rb);
      end
    end
  endtask

  task automatic test_twiddle_table();
    int tr[4] = '{-256, 0, 181, 237};
    int ti[4] = '{0, 256, 181, 98};
    int n;
    for (int k = 1; k <= 4; k++) begin
      send_cmd(1, 2, k);
      checks++;
      if (mul_b_real !== 16'(tr[k-1]) || mul_b_imag !== 16'(ti[k-1])) begin
        fails++; $display("[TB] FAIL twiddle_k%0d: got (%0d,%0d), want (%0d,%0d)",
                          k, mul_b_real, mul_b_imag, tr[k-1], ti[k-1]);
      end
      wait_event(1'b0, 100, n);
      checks++;
      if (n != 21) begin fails++; $display("[TB] FAIL twiddle_k%0d_latency: got %0d, want 21", k, n); end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int n, wb;
    mul_en = 1'b0;
    preload(3, 256, 0);
    preload(7, 0, 128);
    wb = wr_count;
    send_cmd(0, 1, 1);
    wait_event(1'b1, 60, n);
    checks++;
    if (n != 23) begin fails++; $display("[TB] FAIL timeout_err_cycle: got %0d, want 23", n); end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || cmd_ready !== 1'b1 || wr_count != wb) begin
      fails++; $display("[TB] FAIL timeout_recover: err %b ready %b writes %0d, want 0 1 0",
                        err, cmd_ready, wr_count - wb);
    end
    mul_en = 1'b1;
    repeat (4) @(negedge clk);
    send_cmd(0, 1, 2);
    wait_event(1'b0, 100, n);
    checks++;
    if (n != 21) begin fails++; $display("[TB] FAIL timeout_next_latency: got %0d, want 21", n); end
    checks++;
    if (mem_r[3] !== 16'sd0 || mem_i[3] !== 16'sd256 || mem_r[7] !== -16'sd128 || mem_i[7] !== 16'sd0) begin
      fails++; $display("[TB] FAIL timeout_next_data: amp3 (%0d,%0d) amp7 (%0d,%0d), want (0,256) (-128,0)",
                        mem_r[3], mem_i[3], mem_r[7], mem_i[7]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_command();
    int wb;
    bit busy_seen;
    mul_en = 1'b0;
    preload(3, 256, 0);
    send_cmd(0, 1, 1);
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mul_a_real !== 16'sd256) begin
      fails++; $display("[TB] FAIL midreset_pre: busy %b a_real %0d, want 1 256", busy, mul_a_real);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, mem_rd_en, mem_wr_en, mul_start} !== 6'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL midreset_strobes: got %b ready %b, want 000000 1",
                        {busy, done, err, mem_rd_en, mem_wr_en, mul_start}, cmd_ready);
    end
    checks++;
    if (mem_addr !== 3'd0 || mul_a_real !== 16'sd0 || mul_a_imag !== 16'sd0
        || mul_b_real !== 16'sd0 || mul_b_imag !== 16'sd0 || mem_wr_real !== 16'sd0 || mem_wr_imag !== 16'sd0) begin
      fails++; $display("[TB] FAIL midreset_data: addr %0d a (%0d,%0d) b (%0d,%0d), want all 0",
                        mem_addr, mul_a_real, mul_a_imag, mul_b_real, mul_b_imag);
    end
    rst_n = 1'b1;
    mul_en = 1'b1;
    wb = wr_count;
    busy_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    checks++;
    if (wr_count != wb || busy_seen) begin
      fails++; $display("[TB] FAIL midreset_quiet: writes %0d busy_seen %b, want 0 0", wr_count - wb, busy_seen);
    end
  endtask

  task automatic test_back_to_back();
    int n, wb;
    bit ready_low;
    preload(3, 256, 0);
    preload(6, 256, 0);
    preload(7, 0, 128);
    wb = wr_count;
    cmd_ctrl = 2'd0; cmd_tgt = 2'd1; cmd_k = 3'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_ctrl = 2'd1; cmd_tgt = 2'd2; cmd_k = 3'd2;
    n = 1;
    ready_low = 1'b1;
    while (!done && n < 100) begin
      if (cmd_ready !== 1'b0) ready_low = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 21 || !ready_low || cmd_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_first: done at %0d ready_low %b, want 21 1", n, ready_low);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_gap: ready %b busy %b, want 1 0", cmd_ready, busy);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_second_accept: busy %b ready %b, want 1 0", busy, cmd_ready);
    end
    wait_event(1'b0, 100, n);
    checks++;
    if (n != 21 || wr_count - wb != 4) begin
      fails++; $display("[TB] FAIL b2b_second: done at %0d writes %0d, want 21 4", n, wr_count - wb);
    end
    checks++;
    if (mem_r[3] !== -16'sd256 || mem_i[3] !== 16'sd0 || mem_r[6] !== 16'sd0 || mem_i[6] !== 16'sd256
        || mem_r[7] !== 16'sd128 || mem_i[7] !== 16'sd0) begin
      fails++; $display("[TB] FAIL b2b_data: amp3 (%0d,%0d) amp6 (%0d,%0d) amp7 (%0d,%0d), want (-256,0) (0,256) (128,0)",
                        mem_r[3], mem_i[3], mem_r[6], mem_i[6], mem_r[7], mem_i[7]);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rotate_k1();
    test_rotate_k2_k3();
    test_illegal();
    test_twiddle_table();
    test_timeout();
    test_reset_mid_command();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d failures %0d", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
